// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants.
// Holds the fetch state encoding, the default address width and the instruction size.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INSN_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: sequences PC+4, applies execute redirects (even under stall or a
// busy memory), drives the instruction-memory request and the decode/execute flushes.
module fetch_pc_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    input  logic            stall_f,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pc_plus4_f,
    output logic            flush_d,
    output logic            flush_e,
    output logic            misaligned
);

    fetch_state_t    state, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redir_valid, redir_valid_d;
    logic [XLEN-1:0] redir_target, redir_target_d;
    logic [XLEN-1:0] target_aligned;
    logic            fire;

    assign target_aligned = {pc_target_e[XLEN-1:2], 2'b00};

    assign imem_req   = (state != BOOT);
    assign fire       = imem_req & imem_ready & ~stall_f;
    // redir_target always equals pc_q while a redirect is pending
    assign pc_f       = redir_valid ? redir_target : pc_q;
    assign imem_addr  = pc_f;
    assign pc_plus4_f = pc_f + XLEN'(INSN_BYTES);
    assign if_valid   = fire & ~pc_src_e;
    assign flush_d    = pc_src_e;
    assign flush_e    = pc_src_e;
    assign misaligned = pc_src_e & (|pc_target_e[1:0]);

    always_comb begin
        state_d        = state;
        pc_d           = pc_q;
        redir_valid_d  = redir_valid;
        redir_target_d = redir_target;
        if (pc_src_e && fire) begin
            // Target not yet fetched; RUN advances past it on its own fire.
            pc_d          = target_aligned;
            redir_valid_d = 1'b0;
            state_d       = RUN;
        end else if (pc_src_e) begin
            pc_d           = target_aligned;
            redir_valid_d  = 1'b1;
            redir_target_d = target_aligned;
            state_d        = REDIR;
        end else if (fire) begin
            pc_d          = pc_q + XLEN'(INSN_BYTES);
            redir_valid_d = 1'b0;
            state_d       = RUN;
        end else if (state == BOOT) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            pc_q         <= RESET_VECTOR;
            redir_valid  <= 1'b0;
            redir_target <= '0;
        end else begin
            state        <= state_d;
            pc_q         <= pc_d;
            redir_valid  <= redir_valid_d;
            redir_target <= redir_target_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table for the documented scenarios,
// then randomized traffic checked against a fetch-stream reference model.
module tb_fetch_pc_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic        stall_f;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        if_valid;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        flush_d;
    logic        flush_e;
    logic        misaligned;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .stall_f(stall_f), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .if_valid(if_valid), .pc_f(pc_f),
        .pc_plus4_f(pc_plus4_f), .flush_d(flush_d), .flush_e(flush_e),
        .misaligned(misaligned)
    );

    typedef struct {
        logic        rst;
        logic        src;
        logic [31:0] tgt;
        logic        stall;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        e_flush;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic [31:0] t, input logic st,
                       input logic rd, input logic q, input logic [31:0] a,
                       input logic v, input logic f, input logic m);
        vec_t x;
        x.rst = r; x.src = s; x.tgt = t; x.stall = st; x.ready = rd;
        x.e_req = q; x.e_addr = a; x.e_valid = v; x.e_flush = f; x.e_mis = m;
        vecs.push_back(x);
    endtask

    task automatic drive(input logic r, input logic s, input logic [31:0] t,
                         input logic st, input logic rd);
        rst = r; pc_src_e = s; pc_target_e = t; stall_f = st; imem_ready = rd;
    endtask

    task automatic chk_outputs(input logic q, input logic [31:0] a, input logic v,
                               input logic f, input logic m);
        chk("imem_req", 32'(imem_req), 32'(q));
        chk("imem_addr", imem_addr, a);
        chk("pc_f", pc_f, a);
        chk("pc_plus4_f", pc_plus4_f, a + 32'd4);
        chk("if_valid", 32'(if_valid), 32'(v));
        chk("flush_d", 32'(flush_d), 32'(f));
        chk("flush_e", 32'(flush_e), 32'(f));
        chk("misaligned", 32'(misaligned), 32'(m));
    endtask

    // Reference model: where the fetch stream stands and whether boot is still pending.
    logic [31:0] m_pc;
    logic        m_boot;

    initial begin
        int unsigned redir_idx, after_rst_idx;

        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);

        //  rst src tgt           stall ready | req addr          valid flush mis
        add(0, 0, 32'h0,        0, 1,  0, 32'h0000_0000, 0, 0, 0);
        add(0, 0, 32'h0,        0, 1,  1, 32'h0000_0000, 1, 0, 0);
        add(0, 0, 32'h0,        0, 1,  1, 32'h0000_0004, 1, 0, 0);
        add(0, 1, 32'h100,      0, 1,  1, 32'h0000_0008, 0, 1, 0);
        add(0, 0, 32'h0,        0, 1,  1, 32'h0000_0100, 1, 0, 0);
        add(0, 0, 32'h0,        0, 1,  1, 32'h0000_0104, 1, 0, 0);
        add(0, 0, 32'h0,        1, 1,  1, 32'h0000_0108, 0, 0, 0);
        add(0, 1, 32'h200,      1, 1,  1, 32'h0000_0108, 0, 1, 0);
        redir_idx = vecs.size();
        add(0, 0, 32'h0,        1, 1,  1, 32'h0000_0200, 0, 0, 0);
        add(0, 0, 32'h0,        0, 1,  1, 32'h0000_0200, 1, 0, 0);
        add(0, 0, 32'h0,        0, 1,  1, 32'h0000_0204, 1, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 32'h0,    0, 0,  1, 32'h0000_0208, 0, 0, 0);
        add(0, 0, 32'h0,        0, 1,  1, 32'h0000_0208, 1, 0, 0);
        add(0, 1, 32'h103,      0, 1,  1, 32'h0000_020C, 0, 1, 1);
        add(0, 0, 32'h0,        0, 1,  1, 32'h0000_0100, 1, 0, 0);
        add(0, 1, 32'hFFFF_FFFC,0, 1,  1, 32'h0000_0104, 0, 1, 0);
        add(0, 0, 32'h0,        0, 1,  1, 32'hFFFF_FFFC, 1, 0, 0);
        add(0, 0, 32'h0,        0, 1,  1, 32'h0000_0000, 1, 0, 0);
        add(0, 1, 32'h300,      0, 0,  1, 32'h0000_0004, 0, 1, 0);
        add(0, 0, 32'h0,        0, 0,  1, 32'h0000_0300, 0, 0, 0);
        add(1, 0, 32'h0,        0, 0,  1, 32'h0000_0300, 0, 0, 0);
        after_rst_idx = vecs.size();
        add(0, 0, 32'h0,        0, 1,  0, 32'h0000_0000, 0, 0, 0);
        add(0, 0, 32'h0,        0, 1,  1, 32'h0000_0000, 1, 0, 0);
        add(0, 0, 32'h0,        0, 1,  1, 32'h0000_0004, 1, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].src, vecs[i].tgt, vecs[i].stall, vecs[i].ready);
            #2;
            chk_outputs(vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                        vecs[i].e_flush, vecs[i].e_mis);
            if (i == redir_idx) begin
                chk("state_redir", 32'(dut.state), 32'(REDIR));
                chk("redir_valid_set", 32'(dut.redir_valid), 32'd1);
            end
            if (i == after_rst_idx) begin
                chk("state_boot", 32'(dut.state), 32'(BOOT));
                chk("redir_valid_clr", 32'(dut.redir_valid), 32'd0);
            end
        end

        // Randomized phase
        @(negedge clk);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        m_pc   = 32'h0;
        m_boot = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            logic        r, s, st, rd, req, fire;
            logic [31:0] t;
            @(negedge clk);
            r  = ($urandom_range(0, 79) == 0);
            s  = ($urandom_range(0, 5) == 0);
            t  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                              : $urandom;
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 3) != 0);
            drive(r, s, t, st, rd);
            #2;
            req  = !m_boot;
            fire = req && rd && !st;
            chk_outputs(req, m_pc, fire && !s, s, s && (t[1:0] != 2'b00));
            if (r) begin
                m_pc   = 32'h0;
                m_boot = 1'b1;
            end else begin
                m_boot = 1'b0;
                if (s)         m_pc = t & 32'hFFFF_FFFC;
                else if (fire) m_pc = m_pc + 32'd4;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
